// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - load/store bus controller with timeout; optional MISALIGN_TRAP_EN alignment trap
module data_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_m,
    input  logic        mem_write_m,
    input  logic [2:0]  funct3_m,
    input  logic [31:0] addr_m,
    input  logic [31:0] wdata_m,
    output logic [31:0] rdata_m,
    output logic        stall_m,
    output logic        fault_m,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_REQ  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [3:0]    bus_be_q, bus_be_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    off_q, off_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          fault_q, fault_d;

    logic          access, size_ok, misalign, stall_d;
    logic [3:0]    be_sel;
    logic [31:0]   wdata_rep;

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{off, 3'b000} +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b100:  extract = {24'd0, b};
            3'b101:  extract = {16'd0, h};
            default: extract = d;
        endcase
    endfunction

    always_comb begin
        access = mem_read_m | mem_write_m;
        case (funct3_m)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: size_ok = 1'b1;
            default:                                size_ok = 1'b0;
        endcase
`ifdef MISALIGN_TRAP_EN
        misalign = ((funct3_m[1:0] == 2'b01) && addr_m[0]) ||
                   ((funct3_m == 3'b010) && (addr_m[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        case (funct3_m[1:0])
            2'b00: begin
                be_sel    = 4'b0001 << addr_m[1:0];
                wdata_rep = {4{wdata_m[7:0]}};
            end
            2'b01: begin
                be_sel    = addr_m[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_m[15:0]}};
            end
            default: begin
                be_sel    = 4'b1111;
                wdata_rep = wdata_m;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        f3_d        = f3_q;
        off_d       = off_q;
        rdata_d     = rdata_q;
        fault_d     = 1'b0;
        stall_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    stall_d = 1'b1;
                    if (size_ok && !misalign) begin
                        state_d     = S_REQ;
                        cnt_d       = '0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_write_m;
                        bus_addr_d  = {addr_m[31:2], 2'b00};
                        bus_be_d    = be_sel;
                        bus_wdata_d = wdata_rep;
                        f3_d        = funct3_m;
                        off_d       = addr_m[1:0];
                    end else begin
                        state_d = S_DONE;
                        fault_d = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            S_REQ: begin
                stall_d = 1'b1;
                if (bus_ack) begin
                    state_d   = S_DONE;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) rdata_d = extract(f3_q, off_q, bus_rdata);
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    bus_req_d = 1'b0;
                    fault_d   = 1'b1;
                    rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            rdata_q     <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
        end
    end

    // Stall is combinational from the request, so it is gated by reset to stay low while held in reset.
    assign stall_m   = stall_d & reset;
    assign fault_m   = fault_q;
    assign rdata_m   = rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl (honours MISALIGN_TRAP_EN)
module tb_data_mem_ctrl;
    localparam int TO = 6;

    logic        clk;
    logic        reset;
    logic        mem_read_m, mem_write_m;
    logic [2:0]  funct3_m;
    logic [31:0] addr_m, wdata_m, rdata_m;
    logic        stall_m, fault_m;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_ack;

    int checks = 0;
    int failures = 0;

    int          obs_stall, obs_req, obs_fault, obs_fault_after;
    logic        obs_stable, obs_hung, obs_we;
    logic [31:0] obs_addr, obs_wdata, obs_rdata;
    logic [3:0]  obs_be;
    logic [31:0] model_rdata;

    data_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
        .funct3_m(funct3_m), .addr_m(addr_m), .wdata_m(wdata_m),
        .rdata_m(rdata_m), .stall_m(stall_m), .fault_m(fault_m),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit model_misaligned(logic [2:0] f3, logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2) != 0) return 1'b1;
        if (f3 == 3'd2 && (a % 4) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic bit model_valid(logic [2:0] f3);
        return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    endfunction

    function automatic logic [3:0] model_be(logic [2:0] f3, logic [31:0] a);
        if (f3 % 4 == 0) return 4'(1 << (a % 4));
        if (f3 % 4 == 1) return ((a % 4) >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] wd);
        if (f3 % 4 == 0) return (wd % 256) * 32'h0101_0101;
        if (f3 % 4 == 1) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] d);
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: begin
                v = (d / (32'd1 << (8 * (a % 4)))) % 256;
                if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                v = (d / (32'd1 << (16 * ((a / 2) % 2)))) % 65536;
                if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
            end
            default: v = d;
        endcase
        return v;
    endfunction

    // Drives one memory-stage access and records what the bus side did; ack_after < 0 never acks.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rdat, input int ack_after);
        bit first = 1'b1;
        bit done = 1'b0;
        mem_read_m = rd; mem_write_m = wr; funct3_m = f3; addr_m = a; wdata_m = wd;
        bus_ack = 1'b0;
        obs_stall = 0; obs_req = 0; obs_fault = 0; obs_stable = 1'b1;
        obs_we = 1'b0; obs_addr = '0; obs_be = '0; obs_wdata = '0; obs_rdata = '0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (fault_m) obs_fault++;
            if (stall_m) obs_stall++;
            if (bus_req) begin
                if (first) begin
                    obs_we = bus_we; obs_addr = bus_addr; obs_be = bus_be; obs_wdata = bus_wdata;
                    first = 1'b0;
                end else if (bus_we !== obs_we || bus_addr !== obs_addr ||
                             bus_be !== obs_be || bus_wdata !== obs_wdata) begin
                    obs_stable = 1'b0;
                end
                if (obs_req == ack_after) begin
                    bus_ack = 1'b1;
                    bus_rdata = rdat;
                end
                obs_req++;
            end
            if (!stall_m) begin
                done = 1'b1;
                obs_rdata = rdata_m;
            end
            @(posedge clk);
            #1;
            bus_ack = 1'b0;
            bus_rdata = $urandom;
        end
        obs_hung = !done;
        mem_read_m = 1'b0; mem_write_m = 1'b0;
        funct3_m = 3'($urandom); addr_m = $urandom; wdata_m = $urandom;
        @(negedge clk);
        obs_fault_after = (fault_m || stall_m || bus_req) ? 1 : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        mem_read_m = 1'b0; mem_write_m = 1'b0; funct3_m = '0; addr_m = '0; wdata_m = '0;
        bus_rdata = '0; bus_ack = 1'b0;
        #2;
        checks++;
        if ({bus_req, bus_we, stall_m, fault_m, bus_addr, bus_be, bus_wdata, rdata_m} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got req=%b we=%b stall=%b fault=%b addr=%h be=%b wd=%h rd=%h expected all zero",
                     bus_req, bus_we, stall_m, fault_m, bus_addr, bus_be, bus_wdata, rdata_m);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        model_rdata = '0;
    endtask

    task automatic test_lb_sign;
        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF7F, 0);
        checks++; if (obs_hung !== 1'b0) begin failures++; $display("FAIL lb_hung got=%b exp=0", obs_hung); end
        checks++; if (obs_be !== 4'b1000) begin failures++; $display("FAIL lb_be got=%b exp=1000", obs_be); end
        checks++; if (obs_addr !== 32'h100) begin failures++; $display("FAIL lb_addr got=%h exp=00000100", obs_addr); end
        checks++; if (obs_rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffff80", obs_rdata); end
        checks++; if (obs_stall !== 2) begin failures++; $display("FAIL lb_stall got=%0d exp=2", obs_stall); end
        checks++; if (obs_fault !== 0) begin failures++; $display("FAIL lb_fault got=%0d exp=0", obs_fault); end
        model_rdata = 32'hFFFF_FF80;
    endtask

    task automatic test_sh_store;
        run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_BEEF, 32'h1234_5678, 0);
        checks++; if (obs_we !== 1'b1) begin failures++; $display("FAIL sh_we got=%b exp=1", obs_we); end
        checks++; if (obs_be !== 4'b1100) begin failures++; $display("FAIL sh_be got=%b exp=1100", obs_be); end
        checks++; if (obs_wdata !== 32'hBEEF_BEEF) begin failures++; $display("FAIL sh_wdata got=%h exp=beefbeef", obs_wdata); end
        checks++; if (obs_addr !== 32'h200) begin failures++; $display("FAIL sh_addr got=%h exp=00000200", obs_addr); end
        checks++; if (obs_rdata !== model_rdata) begin failures++; $display("FAIL sh_rdata_kept got=%h exp=%h", obs_rdata, model_rdata); end
    endtask

    task automatic test_lw_delayed;
        logic [31:0] d;
        d = $urandom;
        run_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, d, 5);
        checks++; if (obs_req !== 6) begin failures++; $display("FAIL lwd_req_cycles got=%0d exp=6", obs_req); end
        checks++; if (obs_stall !== 7) begin failures++; $display("FAIL lwd_stall got=%0d exp=7", obs_stall); end
        checks++; if (obs_stable !== 1'b1) begin failures++; $display("FAIL lwd_stable got=%b exp=1", obs_stable); end
        checks++; if (obs_rdata !== d) begin failures++; $display("FAIL lwd_rdata got=%h exp=%h", obs_rdata, d); end
        checks++; if (obs_fault !== 0) begin failures++; $display("FAIL lwd_fault got=%0d exp=0", obs_fault); end
        model_rdata = d;
    endtask

    task automatic test_timeout;
        run_access(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 32'h0, -1);
        checks++; if (obs_req !== TO) begin failures++; $display("FAIL to_req_cycles got=%0d exp=%0d", obs_req, TO); end
        checks++; if (obs_fault !== 1) begin failures++; $display("FAIL to_fault got=%0d exp=1", obs_fault); end
        checks++; if (obs_fault_after !== 0) begin failures++; $display("FAIL to_fault_after got=%0d exp=0", obs_fault_after); end
        checks++; if (obs_rdata !== 32'h0) begin failures++; $display("FAIL to_rdata got=%h exp=00000000", obs_rdata); end
        model_rdata = '0;
    endtask

    task automatic test_misalign_word;
        logic [31:0] d;
        d = $urandom;
        run_access(1'b1, 1'b0, 3'b010, 32'h41, 32'h0, d, 0);
`ifdef MISALIGN_TRAP_EN
        checks++; if (obs_req !== 0) begin failures++; $display("FAIL mis_req got=%0d exp=0", obs_req); end
        checks++; if (obs_fault !== 1) begin failures++; $display("FAIL mis_fault got=%0d exp=1", obs_fault); end
        checks++; if (obs_rdata !== 32'h0) begin failures++; $display("FAIL mis_rdata got=%h exp=00000000", obs_rdata); end
        model_rdata = '0;
`else
        checks++; if (obs_addr !== 32'h40) begin failures++; $display("FAIL mis_addr got=%h exp=00000040", obs_addr); end
        checks++; if (obs_be !== 4'b1111) begin failures++; $display("FAIL mis_be got=%b exp=1111", obs_be); end
        checks++; if (obs_rdata !== d) begin failures++; $display("FAIL mis_rdata got=%h exp=%h", obs_rdata, d); end
        model_rdata = d;
`endif
    endtask

    task automatic test_bad_funct3;
        logic [2:0] bad [3];
        bad[0] = 3'b011; bad[1] = 3'b110; bad[2] = 3'b111;
        for (int i = 0; i < 3; i++) begin
            run_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5A5_0000 | 32'(i + 1), 0);
            run_access(1'b1, 1'b0, bad[i], $urandom, $urandom, $urandom, 0);
            checks++;
            if (obs_req !== 0 || obs_stall !== 1 || obs_fault !== 1 || obs_rdata !== 32'h0 || obs_fault_after !== 0) begin
                failures++;
                $display("FAIL bad_f3_%b got req=%0d stall=%0d fault=%0d after=%0d rdata=%h exp req=0 stall=1 fault=1 after=0 rdata=0",
                         bad[i], obs_req, obs_stall, obs_fault, obs_fault_after, obs_rdata);
            end
        end
        model_rdata = '0;
    endtask

    task automatic test_ack_outside;
        bit bad = 1'b0;
        mem_read_m = 1'b0; mem_write_m = 1'b0;
        bus_ack = 1'b1; bus_rdata = $urandom;
        repeat (4) begin
            @(negedge clk);
            if (stall_m || bus_req || fault_m || rdata_m !== model_rdata) bad = 1'b1;
        end
        @(posedge clk);
        #1 bus_ack = 1'b0;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL ack_outside got stall=%b req=%b fault=%b rdata=%h exp idle rdata=%h",
                     stall_m, bus_req, fault_m, rdata_m, model_rdata);
        end
    endtask

    task automatic test_reset_mid_req;
        bit bad = 1'b0;
        mem_read_m = 1'b1; mem_write_m = 1'b0; funct3_m = 3'b010; addr_m = 32'h80; bus_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL rst_mid_pre_req got=%b exp=1", bus_req); end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0 || stall_m !== 1'b0 || fault_m !== 1'b0 || rdata_m !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid_immediate got req=%b stall=%b fault=%b rdata=%h exp all 0",
                     bus_req, stall_m, fault_m, rdata_m);
        end
        @(posedge clk);
        #1 mem_read_m = 1'b0; reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (fault_m || bus_req || stall_m) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL rst_mid_after got fault/req/stall activity exp none"); end
        @(posedge clk);
        #1;
        model_rdata = '0;
    endtask

    task automatic test_random;
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] a, wd, d, exp_rdata;
        int          aa, exp_stall, exp_req, exp_fault;
        bit          valid, bad;
        for (int it = 0; it < 60; it++) begin
            rd = 1'($urandom); wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            f3 = 3'($urandom); a = $urandom; wd = $urandom; d = $urandom;
            aa = int'($urandom_range(0, TO + 1));
            if (aa == TO + 1) aa = -1;
            valid = model_valid(f3) && !model_misaligned(f3, a);
            if (!valid) begin
                exp_stall = 1; exp_req = 0; exp_fault = 1; exp_rdata = '0;
            end else if (aa < 0 || aa >= TO) begin
                exp_stall = TO + 1; exp_req = TO; exp_fault = 1; exp_rdata = '0;
            end else begin
                exp_stall = aa + 2; exp_req = aa + 1; exp_fault = 0;
                exp_rdata = wr ? model_rdata : model_load(f3, a, d);
            end
            run_access(rd, wr, f3, a, wd, d, aa);
            checks++;
            if (obs_hung || obs_stall !== exp_stall || obs_req !== exp_req || obs_fault !== exp_fault ||
                obs_fault_after !== 0 || obs_rdata !== exp_rdata) begin
                failures++;
                $display("FAIL rand%0d_flow f3=%b a=%h rd=%b wr=%b ack=%0d got stall=%0d req=%0d fault=%0d after=%0d rdata=%h hung=%b exp stall=%0d req=%0d fault=%0d rdata=%h",
                         it, f3, a, rd, wr, aa, obs_stall, obs_req, obs_fault, obs_fault_after, obs_rdata, obs_hung,
                         exp_stall, exp_req, exp_fault, exp_rdata);
            end
            if (valid) begin
                bad = (obs_we !== wr) || (obs_addr !== (a & 32'hFFFF_FFFC)) || (obs_be !== model_be(f3, a)) ||
                      (obs_wdata !== model_wdata(f3, wd)) || !obs_stable;
                checks++;
                if (bad) begin
                    failures++;
                    $display("FAIL rand%0d_bus got we=%b addr=%h be=%b wd=%h stable=%b exp we=%b addr=%h be=%b wd=%h stable=1",
                             it, obs_we, obs_addr, obs_be, obs_wdata, obs_stable,
                             wr, a & 32'hFFFF_FFFC, model_be(f3, a), model_wdata(f3, wd));
                end
            end
            model_rdata = exp_rdata;
        end
    endtask

    initial begin
        test_reset();
        test_lb_sign();
        test_sh_store();
        test_lw_delayed();
        test_timeout();
        test_misalign_word();
        test_bad_funct3();
        test_ack_outside();
        test_reset_mid_req();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
